// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Pipeline hazard control for the cases operand bypassing cannot cover:
// load-use RAW against a load in EX, multi-cycle mul/div occupying EX, and
// taken-branch redirect. Produces PC / IF/ID / ID/EX enables and flushes plus
// an EX hold.
//
// Optional build macro: HAZARD_STATS_EN
//   When defined, adds saturating 16-bit event counters LoadUseCnt,
//   MulDivStallCnt and FlushCnt. When undefined those ports do not exist.

module hazard_stall_unit #(
    parameter int MULDIV_STALL = 3   // EX_Hold cycles per mul/div op, 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ID_Rs1,
    input  logic [4:0] ID_Rs2,
    input  logic       ID_UseRs1,
    input  logic       ID_UseRs2,
    input  logic       EX_MemRead,
    input  logic [4:0] EX_rdReg,
    input  logic       EX_MulDiv,
    input  logic       EX_BranchTaken,
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       EX_Hold
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] LoadUseCnt,
    output logic [15:0] MulDivStallCnt,
    output logic [15:0] FlushCnt
`endif
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Reload value for rem when a multi-cycle op starts; the trigger cycle
    // itself is the first hold cycle, so BUSY covers the remaining ones.
    localparam logic [7:0] REM_START = 8'(MULDIV_STALL - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] rem;
    logic [7:0] rem_nxt;

    logic       md_trig;
    logic       hold;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       load_use;
    logic       sel_hold;
    logic       sel_branch;
    logic       sel_load_use;

    // Hazard detection and priority selection (hold > branch > load-use)
    always_comb begin
        // DONE is the release cycle: the op is still flagged in EX but must
        // not start a second hold window.
        md_trig      = (state == RUN) && EX_MulDiv;
        hold         = md_trig || (state == BUSY);
        rs1_hit      = ID_UseRs1 && (ID_Rs1 == EX_rdReg);
        rs2_hit      = ID_UseRs2 && (ID_Rs2 == EX_rdReg);
        // x0 is never a real producer, so it can never create a dependency.
        load_use     = EX_MemRead && (EX_rdReg != 5'd0) && (rs1_hit || rs2_hit);
        sel_hold     = hold;
        sel_branch   = !hold && EX_BranchTaken;
        sel_load_use = !hold && !EX_BranchTaken && load_use;
    end

    // State register and hold counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            rem   <= 8'd0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    // Next-state logic for the mul/div hold sequencer
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        unique case (state)
            RUN: begin
                if (EX_MulDiv) begin
                    if (MULDIV_STALL > 1) begin
                        rem_nxt   = REM_START;
                        state_nxt = BUSY;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            BUSY: begin
                if (rem == 8'd1) begin
                    state_nxt = DONE;
                end else begin
                    rem_nxt = rem - 8'd1;
                end
            end
            DONE: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                rem_nxt   = 8'd0;
            end
        endcase
    end

    // Pipeline control outputs, forced to the safe flush pattern during reset
    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        EX_Hold     = 1'b0;
        if (reset) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (sel_hold) begin
            // EX holds a non-load, non-branch op, so the other hazards
            // cannot be live in EX at the same time.
            EX_Hold     = 1'b1;
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
        end else if (sel_branch) begin
            // ID holds a wrong-path instruction; squash it and redirect.
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (sel_load_use) begin
            // One bubble: next cycle the load is in MEM and the bypass
            // network supplies the value.
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating event counters, one per active priority branch
    always_ff @(posedge clk) begin
        if (reset) begin
            LoadUseCnt     <= 16'd0;
            MulDivStallCnt <= 16'd0;
            FlushCnt       <= 16'd0;
        end else begin
            if (sel_load_use && (LoadUseCnt != 16'hFFFF)) begin
                LoadUseCnt <= LoadUseCnt + 16'd1;
            end
            if (sel_hold && (MulDivStallCnt != 16'hFFFF)) begin
                MulDivStallCnt <= MulDivStallCnt + 16'd1;
            end
            if (sel_branch && (FlushCnt != 16'hFFFF)) begin
                FlushCnt <= FlushCnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit (MULDIV_STALL = 3).
// Expected output vectors are pushed to a scoreboard queue as each cycle's
// stimulus is driven and popped/compared when the outputs are sampled on the
// falling edge. Vector order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold}.

module tb_hazard_stall_unit;

    localparam logic [4:0] E_DEF  = 5'b11000;
    localparam logic [4:0] E_LU   = 5'b00010;
    localparam logic [4:0] E_HOLD = 5'b00001;
    localparam logic [4:0] E_BR   = 5'b11110;
    localparam logic [4:0] E_RST  = 5'b00110;

    logic       clk;
    logic       reset;
    logic [4:0] ID_Rs1;
    logic [4:0] ID_Rs2;
    logic       ID_UseRs1;
    logic       ID_UseRs2;
    logic       EX_MemRead;
    logic [4:0] EX_rdReg;
    logic       EX_MulDiv;
    logic       EX_BranchTaken;
    logic       PCWrite;
    logic       IF_ID_Write;
    logic       IF_ID_Flush;
    logic       ID_EX_Flush;
    logic       EX_Hold;
`ifdef HAZARD_STATS_EN
    logic [15:0] LoadUseCnt;
    logic [15:0] MulDivStallCnt;
    logic [15:0] FlushCnt;
`endif

    logic [4:0] outs;
    assign outs = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold};

    int n_assert = 0;
    int n_fail   = 0;
    logic [4:0] sb[$];

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       md;
        logic       br;
        logic [4:0] exp;
    } step_t;

    hazard_stall_unit #(.MULDIV_STALL(3)) dut (
        .clk(clk),
        .reset(reset),
        .ID_Rs1(ID_Rs1),
        .ID_Rs2(ID_Rs2),
        .ID_UseRs1(ID_UseRs1),
        .ID_UseRs2(ID_UseRs2),
        .EX_MemRead(EX_MemRead),
        .EX_rdReg(EX_rdReg),
        .EX_MulDiv(EX_MulDiv),
        .EX_BranchTaken(EX_BranchTaken),
        .PCWrite(PCWrite),
        .IF_ID_Write(IF_ID_Write),
        .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Flush(ID_EX_Flush),
        .EX_Hold(EX_Hold)
`ifdef HAZARD_STATS_EN
        ,
        .LoadUseCnt(LoadUseCnt),
        .MulDivStallCnt(MulDivStallCnt),
        .FlushCnt(FlushCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic step_t mk(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic u1, input logic u2, input logic mr,
                                 input logic [4:0] rd, input logic md, input logic br,
                                 input logic [4:0] e);
        step_t s;
        s.rst = r; s.rs1 = rs1; s.rs2 = rs2; s.u1 = u1; s.u2 = u2;
        s.mr = mr; s.rd = rd; s.md = md; s.br = br; s.exp = e;
        return s;
    endfunction

    // Apply one cycle of stimulus and record what the outputs must be.
    task automatic drive(input step_t s);
        reset          = s.rst;
        ID_Rs1         = s.rs1;
        ID_Rs2         = s.rs2;
        ID_UseRs1      = s.u1;
        ID_UseRs2      = s.u2;
        EX_MemRead     = s.mr;
        EX_rdReg       = s.rd;
        EX_MulDiv      = s.md;
        EX_BranchTaken = s.br;
        sb.push_back(s.exp);
    endtask

    task automatic test_reset();
        step_t st[$];
        logic [4:0] e;
        st.push_back(mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_RST));
        st.push_back(mk(1, 5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, E_RST));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_DEF));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_assert++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL reset step %0d: got %b expected %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
`ifdef HAZARD_STATS_EN
        n_assert++;
        if ({LoadUseCnt, MulDivStallCnt, FlushCnt} !== 48'd0) begin
            n_fail++;
            $display("FAIL reset counters: got %h/%h/%h expected 0/0/0",
                     LoadUseCnt, MulDivStallCnt, FlushCnt);
        end
`endif
    endtask

    task automatic test_load_use();
        step_t st[$];
        logic [4:0] e;
        // lw x5 in EX, add reading x5 via rs1 -> one bubble, then clear
        st.push_back(mk(0, 5'd5, 5'd7, 1, 1, 1, 5'd5, 0, 0, E_LU));
        st.push_back(mk(0, 5'd5, 5'd7, 1, 1, 0, 5'd5, 0, 0, E_DEF));
        // match via rs2
        st.push_back(mk(0, 5'd3, 5'd9, 1, 1, 1, 5'd9, 0, 0, E_LU));
        // rd = x0 never stalls
        st.push_back(mk(0, 5'd0, 5'd0, 1, 1, 1, 5'd0, 0, 0, E_DEF));
        // rs1 matches but unused, rs2 mismatched
        st.push_back(mk(0, 5'd5, 5'd6, 0, 1, 1, 5'd5, 0, 0, E_DEF));
        // rs2 matches but unused
        st.push_back(mk(0, 5'd1, 5'd12, 1, 0, 1, 5'd12, 0, 0, E_DEF));
        // register match but EX is not a load
        st.push_back(mk(0, 5'd8, 5'd8, 1, 1, 0, 5'd8, 0, 0, E_DEF));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_assert++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL load_use step %0d: got %b expected %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_priority();
        step_t st[$];
        logic [4:0] e;
        // taken branch plus live load-use: branch wins
        st.push_back(mk(0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 1, E_BR));
        // plain taken branch
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, E_BR));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_DEF));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_assert++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL branch step %0d: got %b expected %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_muldiv();
        step_t st[$];
        logic [4:0] e;
        // EX_MulDiv held 4 cycles: hold, hold (branch + load-use ignored), hold, DONE
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_HOLD));
        st.push_back(mk(0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 1, 1, E_HOLD));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_HOLD));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_DEF));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_DEF));
        // trigger cycle with a simultaneous load-use still holds
        st.push_back(mk(0, 5'd4, 5'd0, 1, 0, 1, 5'd4, 1, 0, E_HOLD));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_HOLD));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_HOLD));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_DEF));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_assert++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL muldiv step %0d: got %b expected %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        step_t st[$];
        logic [4:0] e;
        for (int k = 0; k < 2; k++) begin
            st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_HOLD));
            st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_HOLD));
            st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_HOLD));
            st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_DEF));
        end
        // DONE followed by a load-use: normal detection resumes
        st.push_back(mk(0, 5'd2, 5'd0, 1, 0, 1, 5'd2, 0, 0, E_LU));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_assert++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got %b expected %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_busy();
        step_t st[$];
        logic [4:0] e;
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_HOLD));
        st.push_back(mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_RST));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_DEF));
        // back in RUN (not DONE): a new op triggers at once and runs fully
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_HOLD));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_HOLD));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_HOLD));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_DEF));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_DEF));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_assert++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL reset_mid_busy step %0d: got %b expected %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        step_t st[$];
        logic [4:0] e;
        st.push_back(mk(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_RST));
        st.push_back(mk(0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, E_LU));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_DEF));
        st.push_back(mk(0, 5'd0, 5'd6, 0, 1, 1, 5'd6, 0, 0, E_LU));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_HOLD));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_HOLD));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_HOLD));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, E_DEF));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, E_BR));
        st.push_back(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_DEF));
        foreach (st[i]) begin
            drive(st[i]);
            @(negedge clk);
            e = sb.pop_front();
            n_assert++;
            if (outs !== e) begin
                n_fail++;
                $display("FAIL stats step %0d: got %b expected %b", i, outs, e);
            end
            @(posedge clk); #1;
        end
        n_assert++;
        if (LoadUseCnt !== 16'd2) begin
            n_fail++;
            $display("FAIL stats LoadUseCnt: got %0d expected 2", LoadUseCnt);
        end
        n_assert++;
        if (MulDivStallCnt !== 16'd3) begin
            n_fail++;
            $display("FAIL stats MulDivStallCnt: got %0d expected 3", MulDivStallCnt);
        end
        n_assert++;
        if (FlushCnt !== 16'd1) begin
            n_fail++;
            $display("FAIL stats FlushCnt: got %0d expected 1", FlushCnt);
        end
        // run the load-use counter past its ceiling
        drive(mk(0, 5'd5, 5'd0, 1, 0, 1, 5'd5, 0, 0, E_LU));
        void'(sb.pop_front());
        repeat (65540) @(posedge clk);
        #1;
        n_assert++;
        if (LoadUseCnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL stats saturate: got %h expected ffff", LoadUseCnt);
        end
        n_assert++;
        if (MulDivStallCnt !== 16'd3 || FlushCnt !== 16'd1) begin
            n_fail++;
            $display("FAIL stats others: got %0d/%0d expected 3/1", MulDivStallCnt, FlushCnt);
        end
        drive(mk(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, E_DEF));
        void'(sb.pop_front());
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_branch_priority();
        test_muldiv();
        test_back_to_back();
        test_reset_mid_busy();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
